load_store_unit: RTL and testbench

Initiator-side memory access unit between the core's execute/memory stage and the word-organised data RAM. Accepts byte, halfword and word loads/stores from the core, converts them into one or two 32-bit word accesses on the RAM port (read-merge-write for sub-word and misaligned stores), and returns sign/zero-extended load data. It stalls the core for the duration of each access.

---
 rtl/load_store_unit.sv | 158 +++++++++++++++
 tb/tb_load_store_unit.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: byte/half/word loads and stores onto a word-organised RAM.
// Sub-word and misaligned stores use read-merge-write. Optional macro
// LSU_MISALIGNED_EN enables split (two-word) accesses; without it misaligned
// H/W accesses are forced to natural alignment and flagged via `misaligned`.

package types_pkg;
  localparam int DATA_WIDTH = 32;
endpackage

module load_store_unit
  import types_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  stall,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic [DATA_WIDTH-1:0] mem_a,
  output logic [DATA_WIDTH-1:0] mem_wd,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, W0, W1, RESP} state_t;

  state_t                state;
  logic                  we_q;
  logic [2:0]            f3_q;
  logic [DATA_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  mis_q;
  logic [DATA_WIDTH-1:0] cap_q;
  logic [DATA_WIDTH-1:0] cap_nxt;
  logic [DATA_WIDTH-1:0] word_a;
  logic [DATA_WIDTH-1:0] req_ea;
  logic [2:0]            req_size;
  logic [2:0]            size_q;
  logic [1:0]            off;
  logic [2:0]            lane;
  logic                  req_mis;
  logic                  split;

  // funct3[1:0]: 00 byte, 01 half, anything else runs as a full word
  function automatic logic [2:0] size_of(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Stores return zero; B/H loads are sign- or zero-extended by funct3[2]
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] c,
                                                   input logic [2:0] f3, input logic we);
    if (we) return '0;
    case (f3)
      3'b000:  return {{24{c[7]}}, c[7:0]};
      3'b001:  return {{16{c[15]}}, c[15:0]};
      3'b100:  return {24'b0, c[7:0]};
      3'b101:  return {16'b0, c[15:0]};
      default: return c;
    endcase
  endfunction

  assign req_size = size_of(req_funct3);
  assign size_q   = size_of(f3_q);
  assign off      = addr_q[1:0];
  assign word_a   = {addr_q[DATA_WIDTH-1:2], 2'b00};

`ifdef LSU_MISALIGNED_EN
  assign req_ea  = req_addr;
  assign req_mis = 1'b0;
  assign split   = ({1'b0, off} + size_q) > 3'd4;
`else
  // No second word: snap misaligned H/W to the naturally aligned address
  assign req_mis = (req_size == 3'd2 && req_addr[0]) ||
                   (req_size == 3'd4 && req_addr[1:0] != 2'b00);
  assign req_ea  = {req_addr[DATA_WIDTH-1:2],
                    (req_size == 3'd4) ? 2'b00
                                       : {req_addr[1], (req_size == 3'd2) ? 1'b0 : req_addr[0]}};
  assign split   = 1'b0;
`endif

  assign stall = req_valid && (state != RESP) && !rst;

  // RAM port: per access byte k, lane k+off lives in W0 when <4, else in W1
  always_comb begin
    mem_a   = '0;
    mem_wd  = '0;
    mem_we  = 1'b0;
    cap_nxt = cap_q;
    lane    = '0;
    if (state == W0 || state == W1) begin
      mem_a  = (state == W1) ? word_a + 32'd4 : word_a;
      mem_wd = mem_rd;
      mem_we = we_q && !rst;
      for (int k = 0; k < 4; k++) begin
        lane = 3'(k) + {1'b0, off};
        if (3'(k) < size_q && lane[2] == (state == W1)) begin
          mem_wd[8*lane[1:0] +: 8] = wdata_q[8*k +: 8];
          cap_nxt[8*k +: 8]        = mem_rd[8*lane[1:0] +: 8];
        end
      end
    end
  end

  // Access sequencer with registered completion outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      cap_q      <= '0;
      done       <= 1'b0;
      rdata      <= '0;
      misaligned <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          f3_q    <= req_funct3;
          addr_q  <= req_ea;
          wdata_q <= req_wdata;
          mis_q   <= req_mis;
          cap_q   <= '0;
          state   <= W0;
        end
        W0, W1: begin
          cap_q <= cap_nxt;
          if (state == W0 && split) begin
            state <= W1;
          end else begin
            state      <= RESP;
            done       <= 1'b1;
            rdata      <= extend(cap_nxt, f3_q, we_q);
            misaligned <= mis_q;
          end
        end
        default: begin
          state      <= IDLE;
          rdata      <= '0;
          misaligned <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a 256-word behavioural RAM
// (indexed by address bits [9:2]). Expectations follow LSU_MISALIGNED_EN.

module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        stall, done, misaligned, mem_we;
  logic [31:0] rdata, mem_a, mem_wd, mem_rd;

  logic [31:0] ram [256];
  logic        pl_en = 1'b0;
  logic [31:0] pl_a, pl_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .done(done), .rdata(rdata), .misaligned(misaligned),
    .mem_a(mem_a), .mem_wd(mem_wd), .mem_we(mem_we), .mem_rd(mem_rd)
  );

  assign mem_rd = ram[mem_a[9:2]];

  always @(posedge clk) begin
    if (pl_en) ram[pl_a[9:2]] <= pl_d;
    else if (mem_we) ram[mem_a[9:2]] <= mem_wd;
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_a = a; pl_d = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Issues one request and observes it; lat=99 means done never came
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output int lat, output int stl,
                        output logic [31:0] rd, output logic mis, output logic [31:0] last_a);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    lat = 99; stl = 0; rd = 32'hxxxxxxxx; mis = 1'bx; last_a = '0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      if (done) begin lat = c; rd = rdata; mis = misaligned; break; end
      if (stall) stl++;
      last_a = mem_a;
      @(negedge clk);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h12345678;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b exp 0", mem_we); end
    checks++; if ({rdata, mem_a, mem_wd} !== 96'h0) begin errors++;
      $display("FAIL reset_data got %h %h %h exp 0", rdata, mem_a, mem_wd); end
    checks++; if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %b exp 0", misaligned); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
  endtask

  task automatic test_lw();
    int lat, stl; logic [31:0] rd, la; logic mis;
    preload(32'h100, 32'hDEADBEEF);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, lat, stl, rd, mis, la);
    checks++; if (lat !== 2) begin errors++; $display("FAIL lw_latency got %0d exp 2", lat); end
    checks++; if (stl !== 2) begin errors++; $display("FAIL lw_stall_cycles got %0d exp 2", stl); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", rd); end
    checks++; if (la !== 32'h100) begin errors++; $display("FAIL lw_mem_a got %h exp 00000100", la); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL lw_mis got %b exp 0", mis); end
  endtask

  task automatic test_byte();
    int lat, stl; logic [31:0] rd, la; logic mis;
    preload(32'h100, 32'h11223344);
    do_req(1'b1, 3'b000, 32'h103, 32'h000000AA, lat, stl, rd, mis, la);
    checks++; if (ram[64] !== 32'hAA223344) begin errors++; $display("FAIL sb_ram got %h exp aa223344", ram[64]); end
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL sb_rdata got %h exp 0", rd); end
    do_req(1'b0, 3'b000, 32'h103, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'hFFFFFFAA) begin errors++; $display("FAIL lb_data got %h exp ffffffaa", rd); end
    do_req(1'b0, 3'b100, 32'h103, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'h000000AA) begin errors++; $display("FAIL lbu_data got %h exp 000000aa", rd); end
    do_req(1'b0, 3'b000, 32'h101, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'h00000033) begin errors++; $display("FAIL lb_pos_data got %h exp 00000033", rd); end
  endtask

  task automatic test_half();
    int lat, stl; logic [31:0] rd, la; logic mis;
    preload(32'h100, 32'h80015555);
    do_req(1'b0, 3'b101, 32'h102, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'h00008001) begin errors++; $display("FAIL lhu_data got %h exp 00008001", rd); end
    do_req(1'b0, 3'b001, 32'h102, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'hFFFF8001) begin errors++; $display("FAIL lh_data got %h exp ffff8001", rd); end
    do_req(1'b1, 3'b001, 32'h100, 32'hFFFF1234, lat, stl, rd, mis, la);
    checks++; if (ram[64] !== 32'h80011234) begin errors++; $display("FAIL sh_ram got %h exp 80011234", ram[64]); end
  endtask

  task automatic test_misaligned();
    int lat, stl; logic [31:0] rd, la; logic mis;
    preload(32'h104, 32'h0);
    preload(32'h108, 32'h0);
    do_req(1'b1, 3'b010, 32'h106, 32'hCAFEBABE, lat, stl, rd, mis, la);
`ifdef LSU_MISALIGNED_EN
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_split_latency got %0d exp 3", lat); end
    checks++; if (ram[65] !== 32'hBABE0000) begin errors++; $display("FAIL sw_split_w0 got %h exp babe0000", ram[65]); end
    checks++; if (ram[66] !== 32'h0000CAFE) begin errors++; $display("FAIL sw_split_w1 got %h exp 0000cafe", ram[66]); end
    do_req(1'b0, 3'b010, 32'h106, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'hCAFEBABE) begin errors++; $display("FAIL lw_split_data got %h exp cafebabe", rd); end
    checks++; if (mis !== 1'b0) begin errors++; $display("FAIL lw_split_mis got %b exp 0", mis); end
`else
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_mis_latency got %0d exp 2", lat); end
    checks++; if (ram[65] !== 32'hCAFEBABE) begin errors++; $display("FAIL sw_mis_ram got %h exp cafebabe", ram[65]); end
    checks++; if (ram[66] !== 32'h0) begin errors++; $display("FAIL sw_mis_next got %h exp 0", ram[66]); end
    preload(32'h104, 32'h01020304);
    do_req(1'b0, 3'b010, 32'h106, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL lw_mis_data got %h exp 01020304", rd); end
    checks++; if (mis !== 1'b1) begin errors++; $display("FAIL lw_mis_flag got %b exp 1", mis); end
    do_req(1'b0, 3'b001, 32'h105, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'h00000304 || mis !== 1'b1) begin errors++;
      $display("FAIL lh_mis got %h/%b exp 00000304/1", rd, mis); end
`endif
  endtask

  task automatic test_wrap();
    int lat, stl; logic [31:0] rd, la; logic mis;
    preload(32'hFFFFFFFC, 32'hAABB1111);
    preload(32'h0, 32'h2222CCDD);
    do_req(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat, stl, rd, mis, la);
`ifdef LSU_MISALIGNED_EN
    checks++; if (la !== 32'h0) begin errors++; $display("FAIL wrap_mem_a got %h exp 00000000", la); end
    checks++; if (rd !== 32'hCCDDAABB) begin errors++; $display("FAIL wrap_data got %h exp ccddaabb", rd); end
`else
    checks++; if (la !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_mem_a got %h exp fffffffc", la); end
    checks++; if (rd !== 32'hAABB1111) begin errors++; $display("FAIL wrap_data got %h exp aabb1111", rd); end
`endif
  endtask

  task automatic test_reset_mid();
    logic seen_done;
    preload(32'h104, 32'h0);
    preload(32'h108, 32'h0);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h106; req_wdata = 32'h11223344;
    @(posedge clk);
`ifdef LSU_MISALIGNED_EN
    @(posedge clk);
`endif
    #1 rst = 1'b1;
    @(negedge clk);
    checks++; if (mem_we !== 1'b0 || stall !== 1'b0) begin errors++;
      $display("FAIL rstmid_we_stall got %b/%b exp 0/0", mem_we, stall); end
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_done got 1 exp 0"); end
    checks++; if ({rdata, mem_a, mem_wd, misaligned, mem_we, stall} !== 99'h0) begin errors++;
      $display("FAIL rstmid_outputs got %h %h %h %b %b %b exp 0", rdata, mem_a, mem_wd, misaligned, mem_we, stall); end
    checks++; if (ram[66] !== 32'h0) begin errors++; $display("FAIL rstmid_w1 got %h exp 0", ram[66]); end
`ifdef LSU_MISALIGNED_EN
    checks++; if (ram[65] !== 32'h33440000) begin errors++; $display("FAIL rstmid_w0 got %h exp 33440000", ram[65]); end
`else
    checks++; if (ram[65] !== 32'h0) begin errors++; $display("FAIL rstmid_w0 got %h exp 0", ram[65]); end
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat, stl; logic [31:0] rd, la; logic mis;
    preload(32'h100, 32'h0);
    do_req(1'b1, 3'b011, 32'h100, 32'h0BADF00D, lat, stl, rd, mis, la);
    do_req(1'b0, 3'b111, 32'h100, 32'h0, lat, stl, rd, mis, la);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL b2b_data got %h exp 0badf00d", rd); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_latency got %0d exp 2", lat); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte();
    test_half();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
